// File: rtl/gi_mixcol_if.sv
// Handshake bundle for gi_mixcol: state in with mode flags, mixed state out.
interface gi_mixcol_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid, in_state, in_inv, in_last, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_inv, in_last, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/gi_mixcol.sv
// AES MixColumns / InvMixColumns over a full 128-bit state, COLS columns per cycle.
// Define GI_MIX_INV_EN to build the inverse mixer; without it every state is forward-mixed.
module gi_mixcol #(
    parameter int COLS = 1
) (
    input logic        clk,
    input logic        reset,
    gi_mixcol_if.slave bus
);
    localparam int         NSTEP    = 4 / COLS;
    localparam logic [1:0] LAST_CNT = 2'(NSTEP - 1);

    generate
        if (COLS != 1 && COLS != 2 && COLS != 4) begin : g_bad_cols
            $error("gi_mixcol: COLS must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       fsm_q, fsm_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic         last_q, last_d;
`ifdef GI_MIX_INV_EN
    logic         inv_q, inv_d;
`endif

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

`ifdef GI_MIX_INV_EN
    // 9/b/d/e multiples are assembled from the 2x/4x/8x xtime chain of each byte.
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31 - 8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    logic [31:0] col_w   [4];
    logic [1:0]  sel_idx [COLS];
    logic [31:0] mix_w   [COLS];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cols
            assign col_w[gi] = st_q[127 - 32*gi -: 32];
        end
        // Only COLS mixers exist; each one is steered onto its column of the current step.
        for (gi = 0; gi < COLS; gi++) begin : g_mix
            assign sel_idx[gi] = 2'(int'(cnt_q) * COLS + gi);
`ifdef GI_MIX_INV_EN
            assign mix_w[gi] = inv_q ? mix_inv(col_w[sel_idx[gi]])
                                     : mix_fwd(col_w[sel_idx[gi]]);
`else
            assign mix_w[gi] = mix_fwd(col_w[sel_idx[gi]]);
`endif
        end
    endgenerate

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        last_d = last_q;
`ifdef GI_MIX_INV_EN
        inv_d  = inv_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d   = bus.in_state;
                    last_d = bus.in_last;
`ifdef GI_MIX_INV_EN
                    inv_d  = bus.in_inv;
`endif
                    cnt_d  = 2'd0;
                    fsm_d  = bus.in_last ? DONE : MIX;
                end
            end
            MIX: begin
                if (!last_q) begin
                    for (int j = 0; j < COLS; j++) begin
                        st_d[(3 - int'(sel_idx[j]))*32 +: 32] = mix_w[j];
                    end
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 2'd0;
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= IDLE;
            cnt_q  <= 2'd0;
            st_q   <= '0;
            last_q <= 1'b0;
`ifdef GI_MIX_INV_EN
            inv_q  <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            last_q <= last_d;
`ifdef GI_MIX_INV_EN
            inv_q  <= inv_d;
`endif
        end
    end

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.out_state = st_q;

endmodule
